// File: rtl/split_mode_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | split_mode_scheduler_pkg                                             |
// | Shared encodings and sizing for the per-thread barrel controllers.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package split_mode_scheduler_pkg;

   localparam int THREAD_COUNT_DEF = 8;
   localparam int THREAD_WIDTH_DEF = 3;
   localparam int ADDR_WIDTH_DEF   = 10;
   localparam logic [ADDR_WIDTH_DEF-1:0] CFG_ADDR_DEF = 10'h3F0;

   typedef enum logic [1:0] {
      MODE_OFF     = 2'b00,
      MODE_STICKY  = 2'b01,
      MODE_ONESHOT = 2'b10,
      MODE_RSVD    = 2'b11
   } split_mode_e;

   // Reserved code is stored but never asks for a split.
   function automatic logic mode_drives_split(input logic [1:0] mode);
      return (mode == MODE_STICKY) || (mode == MODE_ONESHOT);
   endfunction

endpackage
`default_nettype wire

// File: rtl/split_mode_scheduler_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | thread_round_robin_counter                                           |
// | Free-running wrapping thread counter, async active-low reset.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module thread_round_robin_counter
   import split_mode_scheduler_pkg::*;
#(
   parameter int COUNT = THREAD_COUNT_DEF,
   parameter int WIDTH = THREAD_WIDTH_DEF
) (
   input  logic             clock,
   input  logic             reset_n,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(COUNT - 1);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/split_mode_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | split_mode_scheduler                                                 |
// | Per-thread split-mode control for the barrel D-address splitter.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module split_mode_scheduler
   import split_mode_scheduler_pkg::*;
#(
   parameter int THREAD_COUNT = THREAD_COUNT_DEF,
   parameter int THREAD_WIDTH = THREAD_WIDTH_DEF,
   parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
   parameter logic [ADDR_WIDTH-1:0] CFG_ADDR = CFG_ADDR_DEF
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      cfg_wren,
   input  logic [ADDR_WIDTH-1:0]     cfg_addr,
   input  logic [1:0]                cfg_data,
   input  logic [THREAD_WIDTH-1:0]   cfg_thread,
   output logic [THREAD_WIDTH-1:0]   issue_thread,
   output logic                      split,
   output logic [THREAD_WIDTH-1:0]   split_thread,
   output logic [2*THREAD_COUNT-1:0] mode_state
);

   logic                                cfg_accept;
   logic [THREAD_COUNT-1:0][1:0]        mode_vec;
   logic                                split_q;
   logic                                split_d;
   logic [THREAD_WIDTH-1:0]             split_thread_q;
   logic [THREAD_WIDTH-1:0]             split_thread_d;

   thread_round_robin_counter #(
      .COUNT (THREAD_COUNT),
      .WIDTH (THREAD_WIDTH)
   ) u_rr_counter (
      .clock   (clock),
      .reset_n (reset_n),
      .count   (issue_thread)
   );

   assign cfg_accept = cfg_wren && (cfg_addr == CFG_ADDR);

   generate
      for (genvar t = 0; t < THREAD_COUNT; t++) begin : g_thread
         localparam logic [THREAD_WIDTH-1:0] TID = THREAD_WIDTH'(t);

         logic [1:0] mode_q;
         logic [1:0] mode_d;
         logic [1:0] pend_q;
         logic [1:0] pend_d;
         logic       pend_v_q;
         logic       pend_v_d;
         logic       issuing;
         logic       write_hit;

         assign issuing   = (issue_thread == TID);
         assign write_hit = cfg_accept && (cfg_thread == TID);

         // Commit moves the OLD pending value; a same-cycle write is re-armed for next rotation.
         always_comb begin
            mode_d   = mode_q;
            pend_d   = pend_q;
            pend_v_d = pend_v_q;
            if (issuing && pend_v_q) begin
               mode_d   = pend_q;
               pend_v_d = 1'b0;
            end else if (issuing && (mode_q == MODE_ONESHOT)) begin
               mode_d = MODE_OFF;
            end
            if (write_hit) begin
               pend_d   = cfg_data;
               pend_v_d = 1'b1;
            end
         end

         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               mode_q   <= MODE_OFF;
               pend_q   <= MODE_OFF;
               pend_v_q <= 1'b0;
            end else begin
               mode_q   <= mode_d;
               pend_q   <= pend_d;
               pend_v_q <= pend_v_d;
            end
         end

         assign mode_vec[t] = mode_q;
      end
   endgenerate

   always_comb begin
      split_d        = mode_drives_split(mode_vec[issue_thread]);
      split_thread_d = issue_thread;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         split_q        <= 1'b0;
         split_thread_q <= '0;
      end else begin
         split_q        <= split_d;
         split_thread_q <= split_thread_d;
      end
   end

   assign split        = split_q;
   assign split_thread = split_thread_q;
   assign mode_state   = mode_vec;

endmodule
`default_nettype wire

// File: tb/tb_split_mode_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_split_mode_scheduler                                              |
// | Directed bench with a rotation-level reference model.                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_split_mode_scheduler;

   localparam int NT = 8;
   localparam logic [9:0] CFG = 10'h3F0;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        cfg_wren = 1'b0;
   logic [9:0]  cfg_addr = '0;
   logic [1:0]  cfg_data = '0;
   logic [2:0]  cfg_thread = '0;
   logic [2:0]  issue_thread;
   logic        split;
   logic [2:0]  split_thread;
   logic [15:0] mode_state;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   int m_mode [NT];
   int m_pend [NT];
   bit m_pv   [NT];
   int m_issue;
   int exp_split;
   int exp_sthr;

   split_mode_scheduler dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .cfg_wren     (cfg_wren),
      .cfg_addr     (cfg_addr),
      .cfg_data     (cfg_data),
      .cfg_thread   (cfg_thread),
      .issue_thread (issue_thread),
      .split        (split),
      .split_thread (split_thread),
      .mode_state   (mode_state)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_mode_state();
      int v = 0;
      for (int i = 0; i < NT; i++) v |= (m_mode[i] & 3) << (2 * i);
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NT; i++) begin
         m_mode[i] = 0;
         m_pend[i] = 0;
         m_pv[i]   = 1'b0;
      end
      m_issue   = 0;
      exp_split = 0;
      exp_sthr  = 0;
   endtask

   // One rotation slot: the issuing thread is split on its currently committed mode.
   task automatic model_step(input bit we, input int addr, input int data, input int thr);
      int t = m_issue;
      exp_split = (m_mode[t] == 1 || m_mode[t] == 2) ? 1 : 0;
      exp_sthr  = t;
      if (m_pv[t]) begin
         m_mode[t] = m_pend[t];
         m_pv[t]   = 1'b0;
      end else if (m_mode[t] == 2) begin
         m_mode[t] = 0;
      end
      if (we && addr == CFG) begin
         m_pend[thr] = data;
         m_pv[thr]   = 1'b1;
      end
      m_issue = (t + 1) % NT;
   endtask

   always @(negedge clock) begin
      if (chk_en) begin
         chk("issue_thread", int'(issue_thread), m_issue);
         chk("split", int'(split), exp_split);
         chk("split_thread", int'(split_thread), exp_sthr);
         chk("mode_state", int'(mode_state), model_mode_state());
      end
   end

   task automatic cyc(input bit we, input int addr, input int data, input int thr);
      cfg_wren   = we;
      cfg_addr   = addr[9:0];
      cfg_data   = data[1:0];
      cfg_thread = thr[2:0];
      @(posedge clock);
      model_step(we, addr, data, thr);
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 0);
   endtask

   task automatic wr(input int thr, input int data);
      cyc(1'b1, CFG, data, thr);
   endtask

   initial begin
      model_reset();
      @(negedge clock);
      @(negedge clock);
      chk("rst_issue", int'(issue_thread), 0);
      chk("rst_split", int'(split), 0);
      chk("rst_mode_state", int'(mode_state), 0);
      reset_n = 1'b1;
      chk_en  = 1'b1;

      // Free run two full rotations.
      idle(16);
      chk("wrap_issue", int'(issue_thread), 0);
      chk("idle_mode_state", int'(mode_state), 0);

      // Sticky on thread 3, written while thread 0 issues.
      wr(3, 1);
      idle(3);
      chk("t3_commit_split", int'(split), 0);
      chk("t3_commit_sthr", int'(split_thread), 3);
      chk("t3_mode", int'(mode_state[7:6]), 1);
      idle(8);
      chk("t3_split_a", int'(split), 1);
      chk("t3_sthr_a", int'(split_thread), 3);
      idle(8);
      chk("t3_split_b", int'(split), 1);

      // One-shot on thread 5.
      wr(5, 2);
      idle(1);
      chk("t5_commit_split", int'(split), 0);
      chk("t5_mode_os", int'(mode_state[11:10]), 2);
      idle(8);
      chk("t5_oneshot_split", int'(split), 1);
      chk("t5_oneshot_sthr", int'(split_thread), 5);
      chk("t5_mode_consumed", int'(mode_state[11:10]), 0);
      idle(8);
      chk("t5_after_split", int'(split), 0);

      // Last write wins on thread 2.
      wr(2, 1);
      wr(2, 0);
      idle(3);
      chk("t2_sthr", int'(split_thread), 2);
      chk("t2_split", int'(split), 0);
      chk("t2_mode", int'(mode_state[5:4]), 0);

      // Same-cycle write and commit on thread 6; ignored write to CFG+1.
      wr(6, 1);
      cyc(1'b1, CFG + 1, 2, 0);
      idle(1);
      chk("t6_issue_now", int'(issue_thread), 6);
      wr(6, 2);
      chk("t6_commit_sthr", int'(split_thread), 6);
      chk("t6_commit_split", int'(split), 0);
      chk("t6_mode_sticky", int'(mode_state[13:12]), 1);
      idle(8);
      chk("t6_split_sticky", int'(split), 1);
      chk("t6_mode_os", int'(mode_state[13:12]), 2);
      idle(8);
      chk("t6_split_os", int'(split), 1);
      chk("t6_mode_off", int'(mode_state[13:12]), 0);
      chk("t0_ignored", int'(mode_state[1:0]), 0);

      // Thread 4 one-shot committed, thread 1 pending, then reset mid-cycle.
      wr(4, 2);
      idle(5);
      wr(1, 1);
      chk("t4_mode_os", int'(mode_state[9:8]), 2);
      #2;
      chk_en  = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("arst_issue", int'(issue_thread), 0);
      chk("arst_split", int'(split), 0);
      chk("arst_sthr", int'(split_thread), 0);
      chk("arst_mode_state", int'(mode_state), 0);
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();
      chk_en = 1'b1;
      idle(16);
      chk("post_rst_mode_state", int'(mode_state), 0);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/split_mode_scheduler.md
Name: split_mode_scheduler

Overview:
- Per-thread controller for the split input of the D-address splitter in the multithreaded barrel pipeline.
- Tracks the issuing thread round-robin and holds a split mode for each thread: off, sticky-on, or one-shot.
- Emits a registered split bit aligned with that thread's D operand at the splitter.
- Mode writes arrive from the datapath write port and commit only when the target thread next issues, so no in-flight instruction sees a change mid-pipeline.

Parameters:
- THREAD_COUNT, 8, number of hardware threads; must be a power of two ≥ 2.
- THREAD_WIDTH, 3, log2(THREAD_COUNT).
- ADDR_WIDTH, 10, width of the write-port address.
- CFG_ADDR, 10'h3F0, write address of the split-mode config register.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- cfg_wren  in  1  datapath write enable.
- cfg_addr  in  ADDR_WIDTH  datapath write address.
- cfg_data  in  2  mode to write: 00 off, 01 sticky, 10 one-shot, 11 reserved (treated as off).
- cfg_thread  in  THREAD_WIDTH  thread performing the write; the mode applies to that thread.
- issue_thread  out  THREAD_WIDTH  thread issuing this cycle.
- split  out  1  split control for the splitter, valid for the thread issued one cycle earlier.
- split_thread  out  THREAD_WIDTH  thread that the current split value belongs to.
- mode_state  out  2*THREAD_COUNT  committed mode of every thread, for debug; thread t occupies bits [2t+1:2t].

Behaviour:
- Reset (reset_n low, asynchronous):
  - issue_thread = 0, split = 0, split_thread = 0.
  - All committed modes = off; all pending-valid bits = 0.
  - Reset mid-rotation discards any pending and one-shot state immediately.
- Thread counter:
  - issue_thread increments by 1 every cycle and wraps THREAD_COUNT-1 → 0. There is no stall input.
- Config capture:
  - A write is accepted when cfg_wren = 1 and cfg_addr == CFG_ADDR.
  - On acceptance, pending[cfg_thread] <= cfg_data and pend_v[cfg_thread] <= 1.
  - A second accepted write to the same thread before commit overwrites the pending value (last write wins).
  - Writes to other addresses are ignored.
- Commit:
  - In the cycle that issue_thread == t and pend_v[t] = 1: mode[t] <= pending[t], pend_v[t] <= 0.
  - Output for that issue slot uses the OLD mode[t]. The new mode first affects thread t's next rotation.
- Same-cycle write and commit for the same thread:
  - If an accepted write targets t in the cycle t is committing, the new write wins.
  - It stays pending (pend_v stays 1) and commits on the following rotation.
- Split generation (1-cycle latency, registered):
  - split <= 1 when mode[issue_thread] is 01 or 10; otherwise 0.
  - split_thread <= issue_thread.
- One-shot consumption:
  - When thread t issues with mode[t] = 10, mode[t] <= 00 in the same edge, unless a commit for t occurs that cycle; the commit takes priority.
  - Result: exactly one instruction of t is split per one-shot write.
- Reserved code 11 is stored as 11 but drives split = 0 and is never consumed.
- mode_state reflects committed modes only; pending values are not visible.

Decomposition:
- Shared package:
  - Mode encodings MODE_OFF = 2'b00, MODE_STICKY = 2'b01, MODE_ONESHOT = 2'b10, MODE_RSVD = 2'b11.
  - CFG_ADDR default.
  - Thread-count/width constants shared with the other per-thread controllers.
- Natural sub-module: thread_round_robin_counter, a wrapping counter with async active-low reset, reused by the other per-thread controllers.
- Per-thread mode/pending registers stay in the top level as a generate loop.

Test Plan:
- Reset then free-run 16 cycles → issue_thread steps 0..7,0..7; split = 0 throughout; mode_state = 0.
- Write 01 for thread 3 at cycle 0 while issue_thread = 0 → mode[3] commits at cycle 3 (split = 0 at cycle 4); split = 1 with split_thread = 3 at cycle 12, then every 8 cycles.
- Write 10 for thread 5 → split = 1 for exactly one thread-5 slot after commit; mode_state[11:10] returns to 00; next thread-5 slot gives split = 0.
- Write 01 then 00 for thread 2 before thread 2 issues → only 00 commits; split never asserts for thread 2.
- Accepted write to thread 6 in the same cycle issue_thread = 6 commits an earlier pending 01 → 01 commits now; the new value commits 8 cycles later. Also: write at cfg_addr = CFG_ADDR+1 → ignored.
- Assert reset_n low mid-rotation with thread 4 in one-shot and thread 1 pending → outputs clear asynchronously; after release, split = 0 for all threads and issue_thread restarts at 0.
